// File: rtl/loader_pkg.sv
// Shared definitions for the program loader: FSM states, record framing
// and the opcode field position used when decoding written words.
package loader_pkg;

  typedef enum logic [1:0] {
    LD_LOAD  = 2'd0,
    LD_WRITE = 2'd1,
    LD_RUN   = 2'd2
  } ld_state_e;

  localparam logic [15:0] END_MARK_DEFAULT = 16'hFFFF;
  localparam int          REC_BYTES        = 6;
  localparam logic [2:0]  LAST_IDX         = 3'(REC_BYTES - 1);
  localparam logic [12:0] WC_MAX           = 13'd4096;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 28;

  function automatic logic [3:0] opcode_of(input logic [31:0] instr);
    return instr[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/byte_assembler.sv
// Collects the six big-endian bytes of an address/instruction record and
// flags the address-complete and record-complete bytes as they are accepted.
module byte_assembler
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        restart,
  input  logic        accept,
  input  logic [7:0]  data,
  output logic [15:0] addr,
  output logic [31:0] instr,
  output logic        addr_done,
  output logic        rec_done
);

  logic [2:0]  idx;
  logic [7:0]  addr_hi;
  logic [7:0]  addr_lo;
  logic [23:0] instr_hi;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= 3'd0;
    end else if (restart) begin
      idx <= 3'd0;
    end else if (accept) begin
      idx <= (idx == LAST_IDX) ? 3'd0 : idx + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      case (idx)
        3'd0:                addr_hi  <= data;
        3'd1:                addr_lo  <= data;
        3'd2, 3'd3, 3'd4:    instr_hi <= {instr_hi[15:0], data};
        default:             ;
      endcase
    end
  end

  // The byte on the bus completes the field in the same cycle it is accepted,
  // so the decision logic sees the full value without waiting a cycle.
  assign addr      = {addr_hi, (idx == 3'd1) ? data : addr_lo};
  assign instr     = {instr_hi, data};
  assign addr_done = accept && (idx == 3'd1);
  assign rec_done  = accept && (idx == LAST_IDX);

endmodule

// File: rtl/program_loader.sv
// Loads a byte-streamed program into instruction memory, then releases the
// CPU; a start pulse while running re-arms it for another program.
module program_loader
  import loader_pkg::*;
#(
  parameter int          ADDR_W   = 12,
  parameter logic [15:0] END_MARK = END_MARK_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              start,
  output logic [31:0]       init_w_instr,
  output logic [ADDR_W-1:0] init_w_adrs,
  output logic              init_w_en,
  output logic              cpu_en,
  output logic              err,
  output logic [12:0]       word_count
);

  ld_state_e   state, state_n;
  logic        accept;
  logic        restart;
  logic [15:0] addr;
  logic [31:0] instr;
  logic        addr_done;
  logic        rec_done;
  logic        is_end;
  logic        out_of_range;
  logic        discard;
  logic        rearm;

  assign in_ready  = (state == LD_LOAD);
  assign init_w_en = (state == LD_WRITE);
  assign cpu_en    = (state == LD_RUN);
  assign accept    = in_valid && in_ready;

  assign is_end       = (addr == END_MARK);
  assign out_of_range = ((addr >> ADDR_W) != 16'd0);
  assign rearm        = (state == LD_RUN) && start;
  assign restart      = (addr_done && is_end) || rearm;

  byte_assembler u_asm (
    .clk       (clk),
    .rst       (rst),
    .restart   (restart),
    .accept    (accept),
    .data      (in_data),
    .addr      (addr),
    .instr     (instr),
    .addr_done (addr_done),
    .rec_done  (rec_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LD_LOAD;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      LD_LOAD: begin
        if (addr_done && is_end)      state_n = LD_RUN;
        else if (rec_done && !discard) state_n = LD_WRITE;
      end
      LD_WRITE: state_n = LD_LOAD;
      LD_RUN:   if (start) state_n = LD_RUN == state ? LD_LOAD : state;
      default:  state_n = LD_LOAD;
    endcase
  end

  // Discard flag is re-evaluated on every address, so it never leaks into
  // the following record.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      discard <= 1'b0;
      err     <= 1'b0;
    end else begin
      if (addr_done) discard <= out_of_range && !is_end;
      if (rearm)                                    err <= 1'b0;
      else if (addr_done && !is_end && out_of_range) err <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      init_w_adrs  <= '0;
      init_w_instr <= '0;
    end else if (rec_done && !discard) begin
      init_w_adrs  <= addr[ADDR_W-1:0];
      init_w_instr <= instr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_count <= 13'd0;
    end else if (rearm) begin
      word_count <= 13'd0;
    end else if (state == LD_WRITE && word_count != WC_MAX) begin
      word_count <= word_count + 13'd1;
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: writes are captured by a monitor and
// compared against hand-computed record lists in each scenario task.
module tb_program_loader;
  import loader_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        start = 1'b0;
  logic [31:0] init_w_instr;
  logic [11:0] init_w_adrs;
  logic        init_w_en;
  logic        cpu_en;
  logic        err;
  logic [12:0] word_count;

  int checks = 0;
  int errors = 0;
  int bad_overlap = 0;
  int bad_ready = 0;
  bit gaps = 1'b0;

  typedef struct packed {
    logic [11:0] a;
    logic [31:0] i;
  } wr_t;
  wr_t wq[$];

  logic [15:0] rec_a [5] = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd15};
  logic [31:0] rec_i [5] = '{32'h18001000, 32'h58001000, 32'h3200000F,
                             32'h18001001, 32'h1800F001};

  program_loader #(.ADDR_W(12), .END_MARK(16'hFFFF)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .start        (start),
    .init_w_instr (init_w_instr),
    .init_w_adrs  (init_w_adrs),
    .init_w_en    (init_w_en),
    .cpu_en       (cpu_en),
    .err          (err),
    .word_count   (word_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (init_w_en) wq.push_back('{a: init_w_adrs, i: init_w_instr});
    if (init_w_en && cpu_en) bad_overlap++;
    if (init_w_en && in_ready) bad_ready++;
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    if (gaps) begin
      n = $urandom_range(0, 3);
      repeat (n) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        @(posedge clk); #1;
      end
    end
    in_data  = b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      errors++;
      $display("FAIL send_byte timeout: in_ready=%0b required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_record(input logic [15:0] a, input logic [31:0] i);
    send_byte(a[15:8]); send_byte(a[7:0]);
    send_byte(i[31:24]); send_byte(i[23:16]); send_byte(i[15:8]); send_byte(i[7:0]);
  endtask

  task automatic send_end();
    send_byte(8'hFF); send_byte(8'hFF);
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++; if ({in_ready, init_w_en, cpu_en, err} !== 4'b1000) begin errors++;
      $display("FAIL reset_ctrl: got %b required 1000", {in_ready, init_w_en, cpu_en, err}); end
    checks++; if (word_count !== 13'd0) begin errors++;
      $display("FAIL reset_wc: got %0d required 0", word_count); end
    checks++; if (init_w_adrs !== 12'd0 || init_w_instr !== 32'd0) begin errors++;
      $display("FAIL reset_wdata: got %h/%h required 0/0", init_w_adrs, init_w_instr); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    wq.delete();
    send_record(16'h0000, 32'h18001000);
    checks++; if (init_w_en !== 1'b1 || in_ready !== 1'b0) begin errors++;
      $display("FAIL single_write_cycle: en=%b ready=%b required en=1 ready=0", init_w_en, in_ready); end
    checks++; if (init_w_adrs !== 12'h000 || init_w_instr !== 32'h18001000) begin errors++;
      $display("FAIL single_wdata: got %h/%h required 000/18001000", init_w_adrs, init_w_instr); end
    @(posedge clk); #1;
    checks++; if (init_w_en !== 1'b0 || init_w_instr !== 32'h18001000) begin errors++;
      $display("FAIL single_hold: en=%b instr=%h required 0/18001000", init_w_en, init_w_instr); end
    send_end();
    checks++; if (cpu_en !== 1'b1 || word_count !== 13'd1) begin errors++;
      $display("FAIL single_release: cpu_en=%b wc=%0d required 1/1", cpu_en, word_count); end
    checks++; if (wq.size() !== 1) begin errors++;
      $display("FAIL single_count: got %0d writes required 1", wq.size()); end
    in_data = 8'h00; in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1; in_valid = 1'b0;
    checks++; if (cpu_en !== 1'b1 || in_ready !== 1'b0 || wq.size() !== 1) begin errors++;
      $display("FAIL run_ignores_stream: cpu_en=%b ready=%b writes=%0d required 1/0/1", cpu_en, in_ready, wq.size()); end
  endtask

  task automatic test_reload(input logic exp_err_before);
    checks++; if (err !== exp_err_before) begin errors++;
      $display("FAIL reload_err_before: got %b required %b", err, exp_err_before); end
    pulse_start();
    checks++; if ({cpu_en, in_ready, err} !== 3'b010 || word_count !== 13'd0) begin errors++;
      $display("FAIL reload: cpu_en/ready/err=%b wc=%0d required 010/0", {cpu_en, in_ready, err}, word_count); end
  endtask

  task automatic test_program(input string name);
    wq.delete();
    for (int r = 0; r < 5; r++) begin
      send_record(rec_a[r], rec_i[r]);
      checks++; if (cpu_en !== 1'b0) begin errors++;
        $display("FAIL %s_cpu_en_during_load rec%0d: got %b required 0", name, r, cpu_en); end
      if (r == 2) pulse_start();
    end
    send_end();
    checks++; if (cpu_en !== 1'b1 || word_count !== 13'd5) begin errors++;
      $display("FAIL %s_release: cpu_en=%b wc=%0d required 1/5", name, cpu_en, word_count); end
    checks++; if (wq.size() !== 5) begin errors++;
      $display("FAIL %s_count: got %0d writes required 5", name, wq.size()); end
    for (int r = 0; r < 5 && r < wq.size(); r++) begin
      checks++; if (wq[r].a !== rec_a[r][11:0] || wq[r].i !== rec_i[r]) begin errors++;
        $display("FAIL %s_write%0d: got %h/%h required %h/%h", name, r, wq[r].a, wq[r].i, rec_a[r][11:0], rec_i[r]); end
    end
  endtask

  task automatic test_out_of_range();
    wq.delete();
    send_record(16'h1000, 32'h12345678);
    @(posedge clk); #1;
    checks++; if (wq.size() !== 0 || err !== 1'b1 || word_count !== 13'd0) begin errors++;
      $display("FAIL oor_drop: writes=%0d err=%b wc=%0d required 0/1/0", wq.size(), err, word_count); end
    send_record(16'h0005, 32'hCAFEF00D);
    @(posedge clk); #1;
    checks++; if (wq.size() !== 1 || word_count !== 13'd1) begin errors++;
      $display("FAIL oor_next_count: writes=%0d wc=%0d required 1/1", wq.size(), word_count); end
    else if (wq[0].a !== 12'h005 || wq[0].i !== 32'hCAFEF00D) begin errors++; checks++;
      $display("FAIL oor_next_data: got %h/%h required 005/cafef00d", wq[0].a, wq[0].i); end
    send_end();
    checks++; if (cpu_en !== 1'b1 || err !== 1'b1) begin errors++;
      $display("FAIL oor_release: cpu_en=%b err=%b required 1/1", cpu_en, err); end
  endtask

  task automatic test_reset_mid_record();
    wq.delete();
    send_record(16'h0001, 32'h11112222);
    send_byte(8'h00); send_byte(8'h07); send_byte(8'hDE);
    #2 rst = 1'b1;
    #1;
    checks++; if (word_count !== 13'd0 || init_w_adrs !== 12'd0 || init_w_instr !== 32'd0 || in_ready !== 1'b1) begin errors++;
      $display("FAIL async_reset: wc=%0d adrs=%h instr=%h ready=%b required 0/0/0/1", word_count, init_w_adrs, init_w_instr, in_ready); end
    @(negedge clk); rst = 1'b0;
    wq.delete();
    send_record(16'h0007, 32'hDEADBEEF);
    @(posedge clk); #1;
    checks++; if (wq.size() !== 1 || word_count !== 13'd1) begin errors++;
      $display("FAIL mid_reset_count: writes=%0d wc=%0d required 1/1", wq.size(), word_count); end
    else if (wq[0].a !== 12'h007 || wq[0].i !== 32'hDEADBEEF) begin errors++; checks++;
      $display("FAIL mid_reset_data: got %h/%h required 007/deadbeef", wq[0].a, wq[0].i); end
  endtask

  task automatic test_saturate();
    for (int n = 1; n < 4096; n++) send_record(16'h0003, 32'(n));
    @(posedge clk); #1;
    checks++; if (word_count !== 13'd4096) begin errors++;
      $display("FAIL saturate_reach: got %0d required 4096", word_count); end
    send_record(16'h0ABC, 32'h0BADF00D);
    @(posedge clk); #1;
    checks++; if (word_count !== 13'd4096) begin errors++;
      $display("FAIL saturate_hold: got %0d required 4096", word_count); end
    checks++; if (init_w_adrs !== 12'hABC || init_w_instr !== 32'h0BADF00D || opcode_of(init_w_instr) !== 4'h0) begin errors++;
      $display("FAIL saturate_last_write: got %h/%h required abc/0badf00d", init_w_adrs, init_w_instr); end
  endtask

  task automatic test_invariants();
    checks++; if (bad_overlap !== 0) begin errors++;
      $display("FAIL en_overlap: got %0d cycles required 0", bad_overlap); end
    checks++; if (bad_ready !== 0) begin errors++;
      $display("FAIL ready_in_write: got %0d cycles required 0", bad_ready); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_reload(1'b0);
    test_program("five");
    test_reload(1'b0);
    test_out_of_range();
    test_reload(1'b1);
    gaps = 1'b1;
    test_program("gaps");
    gaps = 1'b0;
    test_reload(1'b0);
    test_reset_mid_record();
    test_saturate();
    test_invariants();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/program_loader.md
# program_loader

Upstream stage of the CPU `top_level`: receives a program as a byte stream over a valid/ready handshake, assembles address/instruction records, and drives the CPU's instruction-memory init port (`init_w_instr`, `init_w_adrs`, `init_w_en`). After an end-of-program record it releases the CPU by raising `cpu_en`. It holds `cpu_en` low for the whole load, so the CPU never fetches a half-written program.

## Interface
- `ADDR_W`, 12: instruction-memory address width. Matches `init_w_adrs`.
- `END_MARK`, 16'hFFFF: 16-bit record address that marks end of program.
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst`  in  1  reset. Asynchronous, active-high.
- `in_data`  in  8  stream byte.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  loader can accept a byte; transfer occurs when `in_valid & in_ready`.
- `start`  in  1  single-cycle pulse. In RUN it re-arms the loader for a new program.
- `init_w_instr`  out  32  instruction to write.
- `init_w_adrs`  out  `ADDR_W`  write address.
- `init_w_en`  out  1  write strobe, one cycle per record.
- `cpu_en`  out  1  CPU run enable.
- `err`  out  1  sticky: a record with an out-of-range address was dropped.
- `word_count`  out  13  records written since the last load began.

## Operation
- **Record format**, big-endian:
  - 2 address bytes: A[15:8], then A[7:0].
  - 4 instruction bytes: I[31:24] … I[7:0].
- **End record**: 2 address bytes equal to `END_MARK`, with no instruction bytes.
- **States**:
  - LOAD: collect bytes; a 3-bit byte index runs 0..5.
  - WRITE: drive the write for one cycle.
  - RUN: program loaded, CPU enabled.
- **LOAD**:
  - `in_ready`=1.
  - Each accepted byte is shifted into the address or instruction register according to the byte index.
  - After byte index 1:
    - If A == `END_MARK`: go to RUN and reset the index.
    - Otherwise, if A[15:ADDR_W] != 0: set `err` and flag the record for discard.
  - After byte index 5:
    - Not flagged: go to WRITE.
    - Flagged: drop the record, return to index 0, stay in LOAD.
- **WRITE**:
  - `init_w_en`=1, `init_w_adrs`=A[ADDR_W-1:0], `init_w_instr`=I, `in_ready`=0.
  - `word_count` increments, saturating at 4096.
  - Next state is LOAD.
- **RUN**:
  - `cpu_en`=1, `in_ready`=0, and the stream is ignored.
  - `start`=1 → LOAD: `cpu_en` drops, `word_count` and `err` clear, byte index=0.
- `start` in LOAD or WRITE is ignored.
- Records may target any address in any order. A duplicate address simply overwrites, and the last write wins.
- `init_w_adrs` and `init_w_instr` are registered and hold their last values outside WRITE.

## Timing
- **Reset values**: state LOAD, byte index 0, `in_ready`=1, `init_w_en`=0, `cpu_en`=0, `init_w_adrs`=0, `init_w_instr`=0, `err`=0, `word_count`=0. Outputs update asynchronously on assertion of `rst`.
- **Reset mid-record** discards the partial record. No write is issued for it.
- **Write latency**: `init_w_en` is high in the cycle immediately after the edge that accepts byte 5. It is high for exactly one cycle.
- **Throughput**: 7 cycles per record at full rate (6 accept cycles + 1 WRITE cycle).
- **Release latency**: `cpu_en` rises on the clock edge after the second `END_MARK` byte is accepted.
- `in_valid` low stalls the loader indefinitely with no state change. `in_data` is sampled only on accepting edges.
- `init_w_en` and `cpu_en` are never high in the same cycle.

## Structure
- Shared package `loader_pkg`:
  - state encoding constants `LD_LOAD`, `LD_WRITE`, `LD_RUN`
  - `END_MARK_DEFAULT`
  - `REC_BYTES`=6
  - instruction opcode field position [31:28], for benches decoding written words
- One natural sub-module: `byte_assembler`, a shift register with byte index and done pulse.
- FSM, error flag and counter stay in `program_loader`.

## Test plan
- **Single record**: bytes 00 00 18 00 10 00, then FF FF → one `init_w_en` pulse with adrs=0, instr=0x18001000; `cpu_en`=1 two cycles later; `word_count`=1.
- **Five-record program**:
  - records (adrs, instr): (0, 0x18001000), (1, 0x58001000), (2, 0x3200000F), (3, 0x18001001), (15, 0x1800F001), then FF FF
  - expect 5 writes in order and `cpu_en`=1; `cpu_en` stays 0 throughout the load
- **Out-of-range address**: record 10 00 12 34 56 78 → no `init_w_en`, `err`=1, `word_count` unchanged; the next valid record writes normally.
- **Back-pressure and gaps**: toggle `in_valid` randomly → identical writes to the back-to-back case; `in_ready`=0 during WRITE.
- **Reset mid-record**: assert `rst` after 3 bytes, then send a full record (adrs 7, instr 0xDEADBEEF) → exactly one write with adrs=7, instr=0xDEADBEEF.
- **Reload**: `start` pulse in RUN → `cpu_en`=0, `word_count`=0, `err`=0; a new program loads and `cpu_en` re-rises.
